// File: rtl/reg_file_a64.sv
// General-purpose register file: X0..X(NUM_REGS-1), SP, NZCV and a per-register pending scoreboard.
// Define REG_FILE_A64_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_a64 #(
    parameter int unsigned          DATA_W   = 64,
    parameter int unsigned          ADDR_W   = 5,
    parameter int unsigned          NUM_REGS = 31,
    parameter logic [DATA_W-1:0]    SP_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] rd_sel_1,
    input  logic              rd_use_sp_1,
    output logic [DATA_W-1:0] rd_data_1,
    output logic              rd_pend_1,

    input  logic [ADDR_W-1:0] rd_sel_2,
    input  logic              rd_use_sp_2,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_pend_2,

    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic              wr_use_sp,
    input  logic              wr_sf,
    input  logic [DATA_W-1:0] wr_data,

    input  logic              nzcv_wr_en,
    input  logic [3:0]        nzcv_in,
    output logic [3:0]        nzcv_out,

    input  logic              pend_set_en,
    input  logic [ADDR_W-1:0] pend_set_sel
);

    localparam logic [ADDR_W-1:0] ZrIdx    = '1;
    localparam logic [ADDR_W-1:0] NumRegsA = ADDR_W'(NUM_REGS);

    // Scoreboard bit NUM_REGS tracks SP.
    logic [DATA_W-1:0] x_q [NUM_REGS];
    logic [DATA_W-1:0] sp_q;
    logic [3:0]        nzcv_q;
    logic [NUM_REGS:0] pend_q, pend_d;
    logic [NUM_REGS:0] set_mask, clr_mask;

    logic              wr_hit_x, wr_hit_sp;
    logic [DATA_W-1:0] wr_val;

    assign wr_hit_x  = wr_en && (wr_sel < NumRegsA);
    assign wr_hit_sp = wr_en && (wr_sel == ZrIdx) && wr_use_sp;
    assign wr_val    = wr_sf ? wr_data : {{(DATA_W/2){1'b0}}, wr_data[DATA_W/2-1:0]};

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wr_hit_x)  clr_mask[wr_sel]   = 1'b1;
        if (wr_hit_sp) clr_mask[NUM_REGS] = 1'b1;
        if (pend_set_en) begin
            if (pend_set_sel == ZrIdx)         set_mask[NUM_REGS]     = 1'b1;
            else if (pend_set_sel < NumRegsA)  set_mask[pend_set_sel] = 1'b1;
        end
        // Set after clear: a newly issued producer outranks the retiring one.
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) x_q[i] <= '0;
            sp_q   <= SP_RESET;
            nzcv_q <= '0;
            pend_q <= '0;
        end else begin
            if (wr_hit_x)   x_q[wr_sel] <= wr_val;
            if (wr_hit_sp)  sp_q        <= wr_val;
            if (nzcv_wr_en) nzcv_q      <= nzcv_in;
            pend_q <= pend_d;
        end
    end

    logic [ADDR_W-1:0] sel      [2];
    logic              use_sp   [2];
    logic [DATA_W-1:0] rd_data  [2];
    logic              rd_pend  [2];

    assign sel[0]    = rd_sel_1;
    assign sel[1]    = rd_sel_2;
    assign use_sp[0] = rd_use_sp_1;
    assign use_sp[1] = rd_use_sp_2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic set_now;
            logic fwd;
            rd_data[p] = '0;
            rd_pend[p] = 1'b0;
            set_now    = pend_set_en && (pend_set_sel == sel[p]);
            fwd        = 1'b0;
            if (sel[p] == ZrIdx) begin
                if (use_sp[p]) begin
                    rd_data[p] = sp_q;
                    rd_pend[p] = pend_q[NUM_REGS] | set_now;
                    fwd        = wr_hit_sp;
                end
            end else if (sel[p] < NumRegsA) begin
                rd_data[p] = x_q[sel[p]];
                rd_pend[p] = pend_q[sel[p]] | set_now;
                fwd        = wr_hit_x && (wr_sel == sel[p]);
            end else begin
                rd_pend[p] = set_now;
            end
`ifdef REG_FILE_A64_BYPASS_EN
            if (fwd) begin
                rd_data[p] = wr_val;
                rd_pend[p] = set_now;
            end
`else
            fwd = fwd & 1'b0;
`endif
        end
    end

    assign rd_data_1 = rd_data[0];
    assign rd_pend_1 = rd_pend[0];
    assign rd_data_2 = rd_data[1];
    assign rd_pend_2 = rd_pend[1];
    assign nzcv_out  = nzcv_q;

endmodule

// File: tb/tb_reg_file_a64.sv
// Directed self-checking bench for reg_file_a64 (default parameters).
module tb_reg_file_a64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_sel_1, rd_sel_2, wr_sel, pend_set_sel;
    logic        rd_use_sp_1, rd_use_sp_2, wr_use_sp, wr_sf, wr_en;
    logic [63:0] rd_data_1, rd_data_2, wr_data;
    logic        rd_pend_1, rd_pend_2;
    logic        nzcv_wr_en, pend_set_en;
    logic [3:0]  nzcv_in, nzcv_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_a64 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_sel_1     (rd_sel_1),
        .rd_use_sp_1  (rd_use_sp_1),
        .rd_data_1    (rd_data_1),
        .rd_pend_1    (rd_pend_1),
        .rd_sel_2     (rd_sel_2),
        .rd_use_sp_2  (rd_use_sp_2),
        .rd_data_2    (rd_data_2),
        .rd_pend_2    (rd_pend_2),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_use_sp    (wr_use_sp),
        .wr_sf        (wr_sf),
        .wr_data      (wr_data),
        .nzcv_wr_en   (nzcv_wr_en),
        .nzcv_in      (nzcv_in),
        .nzcv_out     (nzcv_out),
        .pend_set_en  (pend_set_en),
        .pend_set_sel (pend_set_sel)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wr_en       = 1'b0;
        wr_use_sp   = 1'b0;
        wr_sf       = 1'b1;
        nzcv_wr_en  = 1'b0;
        pend_set_en = 1'b0;
    endtask

    task automatic write(input logic [4:0] sel, input logic [63:0] data,
                         input logic sf, input logic use_sp);
        wr_en     = 1'b1;
        wr_sel    = sel;
        wr_data   = data;
        wr_sf     = sf;
        wr_use_sp = use_sp;
    endtask

    initial begin
        rd_sel_1 = 5'd0; rd_sel_2 = 5'd0; rd_use_sp_1 = 1'b0; rd_use_sp_2 = 1'b0;
        wr_sel = 5'd0; wr_data = '0; pend_set_sel = 5'd0; nzcv_in = 4'h0;
        quiet();

        // 1. reset overrides write, flags and pend_set
        rst_n = 1'b0;
        write(5'd5, 64'hDEAD, 1'b1, 1'b0);
        nzcv_wr_en = 1'b1; nzcv_in = 4'hF;
        pend_set_en = 1'b1; pend_set_sel = 5'd5;
        tick(); tick();
        rst_n = 1'b1;
        quiet();
        rd_sel_1 = 5'd5; rd_sel_2 = 5'd31; rd_use_sp_2 = 1'b1;
        #1;
        check("rst_x5", rd_data_1, 64'h0);
        check("rst_sp", rd_data_2, 64'h0);
        check("rst_nzcv", {60'h0, nzcv_out}, 64'h0);
        check("rst_pend1", {63'h0, rd_pend_1}, 64'h0);
        check("rst_pend2", {63'h0, rd_pend_2}, 64'h0);

        // 2. X write then W write clears upper half
        write(5'd3, 64'hFFFF_FFFF_1234_5678, 1'b1, 1'b0);
        tick(); quiet();
        rd_sel_1 = 5'd3;
        #1 check("x3_full", rd_data_1, 64'hFFFF_FFFF_1234_5678);
        write(5'd3, 64'hAAAA_AAAA_8765_4321, 1'b0, 1'b0);
        tick(); quiet();
        #1 check("x3_w", rd_data_1, 64'h0000_0000_8765_4321);

        // 3. index 31: SP write kept, XZR write discarded
        write(5'd31, 64'h1000, 1'b1, 1'b1);
        tick();
        write(5'd31, 64'h55, 1'b1, 1'b0);
        tick(); quiet();
        rd_sel_1 = 5'd31; rd_use_sp_1 = 1'b1;
        rd_sel_2 = 5'd31; rd_use_sp_2 = 1'b0;
        #1;
        check("sp_rd", rd_data_1, 64'h1000);
        check("xzr_rd", rd_data_2, 64'h0);

        // 4. scoreboard on X7
        rd_sel_1 = 5'd7; rd_use_sp_1 = 1'b0;
        pend_set_en = 1'b1; pend_set_sel = 5'd7;
        #1 check("pend_same", {63'h0, rd_pend_1}, 64'h1);
        tick(); quiet();
        #1 check("pend_next", {63'h0, rd_pend_1}, 64'h1);
        write(5'd7, 64'h70, 1'b1, 1'b0);
        pend_set_en = 1'b1; pend_set_sel = 5'd7;
        tick(); quiet();
        #1 check("pend_set_wins", {63'h0, rd_pend_1}, 64'h1);
        write(5'd7, 64'h77, 1'b1, 1'b0);
        #1;
`ifdef REG_FILE_A64_BYPASS_EN
        check("pend_clr_fwd", {63'h0, rd_pend_1}, 64'h0);
`else
        check("pend_clr_same", {63'h0, rd_pend_1}, 64'h1);
`endif
        tick(); quiet();
        #1 check("pend_clr", {63'h0, rd_pend_1}, 64'h0);

        // SP scoreboard: discarded XZR write must not clear it
        rd_sel_1 = 5'd31; rd_use_sp_1 = 1'b1;
        pend_set_en = 1'b1; pend_set_sel = 5'd31;
        tick(); quiet();
        #1;
        check("sp_pend", {63'h0, rd_pend_1}, 64'h1);
        check("xzr_pend", {63'h0, rd_pend_2}, 64'h0);
        write(5'd31, 64'h99, 1'b1, 1'b0);
        tick(); quiet();
        #1 check("sp_pend_kept", {63'h0, rd_pend_1}, 64'h1);
        write(5'd31, 64'h2000, 1'b1, 1'b1);
        tick(); quiet();
        #1;
        check("sp_pend_clr", {63'h0, rd_pend_1}, 64'h0);
        check("sp_2000", rd_data_1, 64'h2000);

        // 5. same-cycle read of a register being written
        rd_sel_1 = 5'd9; rd_use_sp_1 = 1'b0;
        write(5'd9, 64'h42, 1'b1, 1'b0);
        #1;
`ifdef REG_FILE_A64_BYPASS_EN
        check("x9_same", rd_data_1, 64'h42);
`else
        check("x9_same", rd_data_1, 64'h0);
`endif
        tick(); quiet();
        #1 check("x9_next", rd_data_1, 64'h42);

        // 6. flags and write together, then flags under reset
        nzcv_wr_en = 1'b1; nzcv_in = 4'b0110;
        write(5'd1, 64'h7, 1'b1, 1'b0);
        tick(); quiet();
        rd_sel_1 = 5'd1;
        #1;
        check("nzcv_0110", {60'h0, nzcv_out}, 64'h6);
        check("x1_7", rd_data_1, 64'h7);
        rst_n = 1'b0;
        nzcv_wr_en = 1'b1; nzcv_in = 4'b1111;
        tick();
        rst_n = 1'b1; quiet();
        #1;
        check("nzcv_rst", {60'h0, nzcv_out}, 64'h0);
        check("x1_rst", rd_data_1, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
